mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single-port instruction/data memory between the fetch stage (I side) and the load/store stage (D side) of the multi-cycle RISC-V core. Each cycle it grants at most one requester, drives the memory port, and routes the read data back after a fixed memory latency with a one-cycle valid pulse. Ties between the two sides are broken round-robin. This makes the fetch and memory states of the core controller independent of memory timing.

## Interface
- MEM_LAT, 1: memory read latency in cycles from the mem_en edge to mem_rdata valid; legal range 1..4.
- clk  in  1  core clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  32  fetch byte address; stable while i_req && !i_gnt.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  one-cycle pulse when i_rdata is valid.
- i_rdata  out  32  instruction word.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  4  byte write strobes; 0 means a load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  load/store accepted this cycle.
- d_rvalid  out  1  one-cycle completion pulse, for loads and stores.
- d_rdata  out  32  load data; 0 on store completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  byte write enables to memory.
- mem_addr  out  32  word address to memory, equal to the granted address [31:2] zero-extended.
- mem_wdata  out  32  write data to memory.
- mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.

## Operation
- States:
  - IDLE: no transaction outstanding.
  - BUSY: one transaction outstanding, with owner flag own (I or D) and latency counter cnt (3 bits).
- Grant is allowed (slot free) when:
  - the state is IDLE, or
  - the state is BUSY and cnt == MEM_LAT, i.e. the completion cycle.
- Selection when the slot is free:
  - Only one side requesting: that side wins.
  - Both sides requesting: the side not granted last wins (last register).
- Grant effects (combinational in the grant cycle):
  - The winner's gnt = 1.
  - mem_en = 1, and mem_addr, mem_we, mem_wdata come from the winner.
  - The I side always drives mem_we = 0 and mem_wdata = 0.
- Registered on the grant edge: state = BUSY, own = winner, cnt = 1, last = winner.
- In BUSY with cnt < MEM_LAT: cnt increments; no grant is given.
- Completion cycle (BUSY, cnt == MEM_LAT):
  - The owner's rvalid = 1.
  - Owner's rdata = mem_rdata for a load or fetch, and 0 for a store.
  - A new grant may occur in the same cycle. Without one, the next state is IDLE.
- Non-owner rvalid is 0 and its rdata is 0. All rdata outputs are 0 whenever rvalid is 0.
- Outputs with no grant in the cycle: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Requests seen while the slot is busy are ignored, with no gnt. A requester must hold req and its payload until it sees gnt.
- Requester dropping req before gnt: legal, and nothing is recorded.
- The D side has no priority beyond round-robin. Worst-case wait is one transaction of the other side.

## Timing
- Reset (rstn = 0, asynchronous):
  - state = IDLE, cnt = 0, own = I, last = D, so the first tie goes to I.
  - All outputs are 0 while in reset and in the first cycle after release if no request is present.
- Reset mid-transaction aborts the access: no rvalid is ever produced for it.
- Grant is combinational from req and state. There is no cycle of latency from req to gnt when the slot is free.
- rvalid is asserted exactly MEM_LAT cycles after the gnt cycle.
- Throughput is one transaction every MEM_LAT cycles. With MEM_LAT = 1, back-to-back accesses run one per cycle.
- If the completion cycle grants the same owner again, rvalid (old) and gnt (new) are both 1 in that cycle.
- No combinational path from mem_rdata to any gnt.

## Test plan
- Reset state: rstn = 0 mid-BUSY with MEM_LAT = 2 -> all outputs 0 immediately; after release with no requests, mem_en = 0 and no rvalid ever appears.
- Single fetch, MEM_LAT = 1: i_req = 1, i_addr = 0x10 at cycle t -> i_gnt = 1, mem_en = 1, mem_addr = 0x4 at t; at t+1 i_rvalid = 1 and i_rdata = mem_rdata (0x00500093).
- Tie after reset: i_req = d_req = 1 at t -> I granted at t, D granted at t+1 (MEM_LAT = 1); continuous ties alternate I, D, I, D.
- Store, MEM_LAT = 3: d_req = 1, d_we = 0xF, d_addr = 0x100, d_wdata = 0xDEADBEEF -> mem_we = 0xF, mem_addr = 0x40 at t; d_rvalid = 1 with d_rdata = 0 at t+3; an i_req held from t+1 gets no i_gnt until t+3.
- Byte store: d_we = 0x2, d_addr = 0x103 -> mem_we = 0x2, mem_addr = 0x40; i_rvalid stays 0 throughout.
- Back-to-back D loads, MEM_LAT = 2, i_req = 0: grants at t, t+2, t+4; d_rvalid at t+2, t+4, t+6, coinciding with the next grant.

Source files
------------

// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
// Round-robin arbiter sharing one fixed-latency memory port between fetch and load/store.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] c_lat   = 3'(MEM_LAT);
  localparam logic       c_own_i = 1'b0;
  localparam logic       c_own_d = 1'b1;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_own, w_own_nxt;
  logic       r_last, w_last_nxt;
  logic       r_store, w_store_nxt;

  logic       w_done;
  logic       w_free;
  logic       w_sel_d;
  logic       w_grant;
  logic       w_unused_addr_lsbs;

  assign w_unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_own   <= c_own_i;
      r_last  <= c_own_d;
      r_store <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_own   <= w_own_nxt;
      r_last  <= w_last_nxt;
      r_store <= w_store_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_own_nxt   = r_own;
    w_last_nxt  = r_last;
    w_store_nxt = r_store;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    i_rdata     = 32'd0;
    d_rvalid    = 1'b0;
    d_rdata     = 32'd0;
    mem_en      = 1'b0;
    mem_we      = 4'd0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;

    w_done = (r_state == BUSY) && (r_cnt == c_lat);
    w_free = (r_state == IDLE) || w_done;
    if (i_req && d_req) begin
      w_sel_d = (r_last == c_own_i);
    end else begin
      w_sel_d = d_req;
    end
    // Gated by rstn so nothing is granted while reset is held.
    w_grant = rstn && w_free && (i_req || d_req);

    if (w_done) begin
      if (r_own == c_own_d) begin
        d_rvalid = 1'b1;
        d_rdata  = r_store ? 32'd0 : mem_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
    end

    if (w_grant) begin
      mem_en = 1'b1;
      if (w_sel_d) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = {2'b00, d_addr[31:2]};
        mem_wdata = d_wdata;
      end else begin
        i_gnt    = 1'b1;
        mem_addr = {2'b00, i_addr[31:2]};
      end
      w_state_nxt = BUSY;
      w_cnt_nxt   = 3'd1;
      w_own_nxt   = w_sel_d;
      w_last_nxt  = w_sel_d;
      w_store_nxt = w_sel_d && (d_we != 4'd0);
    end else if (w_done) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 3'd0;
    end else if (r_state == BUSY) begin
      w_cnt_nxt = r_cnt + 3'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
// Three arbiters (MEM_LAT = 1, 2, 3) exercised with directed and random traffic.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_arbiter;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_req     [N];
  logic [31:0] i_addr    [N];
  logic        d_req     [N];
  logic [3:0]  d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic [31:0] mem_rdata;
  logic        i_gnt     [N];
  logic        i_rvalid  [N];
  logic [31:0] i_rdata   [N];
  logic        d_gnt     [N];
  logic        d_rvalid  [N];
  logic [31:0] d_rdata   [N];
  logic        mem_en    [N];
  logic [3:0]  mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      mem_port_arbiter #(.MEM_LAT(k + 1)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_req     (i_req[k]),
        .i_addr    (i_addr[k]),
        .i_gnt     (i_gnt[k]),
        .i_rvalid  (i_rvalid[k]),
        .i_rdata   (i_rdata[k]),
        .d_req     (d_req[k]),
        .d_we      (d_we[k]),
        .d_addr    (d_addr[k]),
        .d_wdata   (d_wdata[k]),
        .d_gnt     (d_gnt[k]),
        .d_rvalid  (d_rvalid[k]),
        .d_rdata   (d_rdata[k]),
        .mem_en    (mem_en[k]),
        .mem_we    (mem_we[k]),
        .mem_addr  (mem_addr[k]),
        .mem_wdata (mem_wdata[k]),
        .mem_rdata (mem_rdata)
      );
    end
  endgenerate

  // Output bundle: {i_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, i_rvalid, i_rdata, d_rvalid, d_rdata}
  function automatic logic [136:0] pack(input logic gi, input logic gd, input logic en,
                                        input logic [3:0] we, input logic [31:0] a,
                                        input logic [31:0] wd, input logic iv,
                                        input logic [31:0] ir, input logic dv,
                                        input logic [31:0] dr);
    return {gi, gd, en, we, a, wd, iv, ir, dv, dr};
  endfunction

  function automatic logic [136:0] obs(input int k);
    return {i_gnt[k], d_gnt[k], mem_en[k], mem_we[k], mem_addr[k], mem_wdata[k],
            i_rvalid[k], i_rdata[k], d_rvalid[k], d_rdata[k]};
  endfunction

  task automatic do_reset();
    for (int k = 0; k < N; k++) begin
      i_req[k] = 1'b0; i_addr[k] = 32'd0; d_req[k] = 1'b0;
      d_we[k] = 4'd0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
    end
    mem_rdata = 32'd0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic test_reset();
    logic [136:0] got;
    do_reset();
    d_req[1] = 1'b1; d_addr[1] = 32'h20;
    @(negedge clk);
    got = obs(1); checks++;
    if (got !== pack(1'b0, 1'b1, 1'b1, 4'h0, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0))
      $display("FAIL reset_pre_grant: got %h", got);
    else passed++;
    @(posedge clk); #1 d_req[1] = 1'b0; mem_rdata = 32'hCAFEF00D;
    #2 rstn = 1'b0; i_req[1] = 1'b1;
    #1 got = obs(1); checks++;
    if (got !== '0) $display("FAIL reset_immediate: got %h want 0", got); else passed++;
    @(negedge clk);
    got = obs(1); checks++;
    if (got !== '0) $display("FAIL reset_held: got %h want 0", got); else passed++;
    @(posedge clk); #1 i_req[1] = 1'b0; rstn = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      got = obs(1); checks++;
      if (got !== '0) $display("FAIL reset_after_release c%0d: got %h want 0", n, got);
      else passed++;
    end
  endtask

  task automatic test_single_fetch();
    logic [136:0] got;
    do_reset();
    i_req[0] = 1'b1; i_addr[0] = 32'h10; mem_rdata = 32'h00500093;
    @(negedge clk);
    got = obs(0); checks++;
    if (got !== pack(1'b1, 1'b0, 1'b1, 4'h0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0))
      $display("FAIL fetch_grant: got %h", got);
    else passed++;
    @(posedge clk); #1 i_req[0] = 1'b0;
    @(negedge clk);
    got = obs(0); checks++;
    if (got !== pack(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h00500093, 1'b0, 32'h0))
      $display("FAIL fetch_rvalid: got %h", got);
    else passed++;
  endtask

  task automatic test_tie();
    logic [136:0] got, want;
    logic gi, prev;
    do_reset();
    i_req[0] = 1'b1; i_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_addr[0] = 32'h80; d_wdata[0] = 32'h11111111;
    for (int n = 0; n < 6; n++) begin
      mem_rdata = $urandom;
      gi = (n % 2 == 0);
      prev = (n > 0);
      want = pack(gi, !gi, 1'b1, 4'h0, gi ? 32'h10 : 32'h20, gi ? 32'h0 : 32'h11111111,
                  prev && !gi, (prev && !gi) ? mem_rdata : 32'h0,
                  prev && gi,  (prev && gi)  ? mem_rdata : 32'h0);
      @(negedge clk);
      got = obs(0); checks++;
      if (got !== want) $display("FAIL tie c%0d: got %h want %h", n, got, want); else passed++;
      @(posedge clk); #1;
    end
    i_req[0] = 1'b0; d_req[0] = 1'b0;
  endtask

  task automatic test_store();
    logic [136:0] got, want;
    do_reset();
    d_req[2] = 1'b1; d_we[2] = 4'hF; d_addr[2] = 32'h100; d_wdata[2] = 32'hDEADBEEF;
    mem_rdata = 32'h12345678;
    for (int n = 0; n < 4; n++) begin
      case (n)
        0: want = pack(1'b0, 1'b1, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 32'h0);
        3: want = pack(1'b1, 1'b0, 1'b1, 4'h0, 32'h80, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        default: want = '0;
      endcase
      @(negedge clk);
      got = obs(2); checks++;
      if (got !== want) $display("FAIL store c%0d: got %h want %h", n, got, want); else passed++;
      @(posedge clk); #1;
      if (n == 0) begin d_req[2] = 1'b0; i_req[2] = 1'b1; i_addr[2] = 32'h200; end
    end
    i_req[2] = 1'b0;
  endtask

  task automatic test_byte_store();
    logic [136:0] got, want;
    do_reset();
    d_req[2] = 1'b1; d_we[2] = 4'h2; d_addr[2] = 32'h103; d_wdata[2] = 32'h0000AB00;
    mem_rdata = 32'h87654321;
    for (int n = 0; n < 5; n++) begin
      case (n)
        0: want = pack(1'b0, 1'b1, 1'b1, 4'h2, 32'h40, 32'h0000AB00, 1'b0, 32'h0, 1'b0, 32'h0);
        3: want = pack(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        default: want = '0;
      endcase
      @(negedge clk);
      got = obs(2); checks++;
      if (got !== want) $display("FAIL byte_store c%0d: got %h want %h", n, got, want);
      else passed++;
      @(posedge clk); #1 d_req[2] = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [136:0] got, want;
    logic g, v;
    do_reset();
    d_req[1] = 1'b1; d_addr[1] = 32'h300;
    for (int n = 0; n < 7; n++) begin
      if (n == 5) d_req[1] = 1'b0;
      mem_rdata = $urandom;
      g = (n == 0) || (n == 2) || (n == 4);
      v = (n == 2) || (n == 4) || (n == 6);
      want = pack(1'b0, g, g, 4'h0, g ? 32'hC0 : 32'h0, 32'h0, 1'b0, 32'h0, v,
                  v ? mem_rdata : 32'h0);
      @(negedge clk);
      got = obs(1); checks++;
      if (got !== want) $display("FAIL back_to_back c%0d: got %h want %h", n, got, want);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  // Reference: a transaction granted at cycle c completes at cycle c + latency.
  task automatic test_random(input int k, input int ncyc);
    logic [136:0] got, want;
    int   lat, cyc, done_at;
    logic pend, pside, pstore, last_d;
    logic done, free, sel_d, g;
    lat = k + 1; cyc = 0; done_at = 0;
    pend = 1'b0; pside = 1'b0; pstore = 1'b0; last_d = 1'b1; g = 1'b0; sel_d = 1'b0;
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      if (!i_req[k] || (g && !sel_d)) begin
        i_req[k] = 1'($urandom_range(0, 1)); i_addr[k] = $urandom;
      end else if ($urandom_range(0, 7) == 0) i_req[k] = 1'b0;
      if (!d_req[k] || (g && sel_d)) begin
        d_req[k] = 1'($urandom_range(0, 1)); d_addr[k] = $urandom; d_wdata[k] = $urandom;
        d_we[k] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end else if ($urandom_range(0, 7) == 0) d_req[k] = 1'b0;
      mem_rdata = $urandom;

      done  = pend && (cyc == done_at);
      free  = !pend || done;
      sel_d = (i_req[k] && d_req[k]) ? !last_d : d_req[k];
      g     = free && (i_req[k] || d_req[k]);
      want = pack(g && !sel_d, g && sel_d, g, (g && sel_d) ? d_we[k] : 4'h0,
                  g ? (sel_d ? (d_addr[k] >> 2) : (i_addr[k] >> 2)) : 32'h0,
                  (g && sel_d) ? d_wdata[k] : 32'h0,
                  done && !pside, (done && !pside) ? mem_rdata : 32'h0,
                  done && pside, (done && pside && !pstore) ? mem_rdata : 32'h0);
      @(negedge clk);
      got = obs(k); checks++;
      if (got !== want)
        $display("FAIL random lat%0d c%0d: got %h want %h", lat, n, got, want);
      else passed++;
      @(posedge clk);
      if (g) begin
        pend = 1'b1; done_at = cyc + lat; pside = sel_d; last_d = sel_d;
        pstore = sel_d && (d_we[k] != 4'h0);
      end else if (done) pend = 1'b0;
      cyc++;
      #1;
    end
  endtask

  initial begin
    rstn = 1'b0;
    test_reset();
    test_single_fetch();
    test_tie();
    test_store();
    test_byte_store();
    test_back_to_back();
    for (int k = 0; k < N; k++) test_random(k, 300);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
